// File: rtl/vec_issue_pkg.sv
// ---------------------------------------------------------------------------
// vec_issue_pkg
//
// Shared types and constants for the vector issue unit:
//   XLEN               data / instruction width
//   issue_state_e      issuer FSM states
//   issue_cmd_t        one buffered command {inst, rs1, rs2}
//   DEFAULT_TIMEOUT    default WAIT_ACK cycle budget
//   timeout_cnt_width  width of a counter that must reach TIMEOUT-1
//   TIMEOUT_CNT_W      counter width for the default budget
// ---------------------------------------------------------------------------
package vec_issue_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } issue_cmd_t;

    localparam int DEFAULT_TIMEOUT = 1024;

    // The wait counter only has to hold 0 .. timeout-1.
    function automatic int timeout_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int TIMEOUT_CNT_W = timeout_cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/vec_issue_fifo.sv
// ---------------------------------------------------------------------------
// vec_issue_fifo
//
// Small synchronous FIFO of issue_cmd_t entries. Pushes into a full FIFO and
// pops from an empty FIFO are ignored. The head entry is presented
// combinationally so the consumer can register it on the pop edge.
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push         write push_data at the tail (ignored when full)
//   push_data    command to store
//   pop          drop the head entry (ignored when empty)
//   head         current head entry (undefined while empty)
//   full, empty  occupancy flags
//   count        number of stored entries, 0 .. DEPTH
// ---------------------------------------------------------------------------
module vec_issue_fifo
    import vec_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  issue_cmd_t                   push_data,
    input  logic                         pop,
    output issue_cmd_t                   head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_cmd_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it out keeps it a plain RAM/regfile.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_issue_unit.sv
// ---------------------------------------------------------------------------
// vec_issue_unit
//
// Scalar-side issuer for the vector processor. Commands from the scalar core
// are buffered in a FIFO and issued one at a time over the instruction
// val/ready interface. Operands are held stable from issue until the
// instruction completes or is abandoned, because the vector datapath decodes
// them combinationally. The completion value (csr_out) is returned to the core
// through a single result register.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cmd_valid/ready     core command handshake (ready = FIFO not full)
//   cmd_inst/rs1/rs2    command payload
//   res_valid/ready     result handshake towards the core
//   res_data            captured csr_out
//   instruction         instruction presented to the vector processor
//   rs1_data, rs2_data  scalar operands presented to the vector processor
//   inst_valid          instruction offered (ISSUE)
//   scalar_pro_ready    issuer can take the completion (WAIT_ACK, no result held)
//   vec_pro_ready       vector processor accepts the instruction
//   vec_pro_ack         vector processor completed the instruction
//   is_vec              presented instruction is a legal vector instruction
//   csr_out             vector CSR read data, captured on completion
//   illegal_inst        one-cycle pulse, instruction rejected
//   timeout_err         one-cycle pulse, completion never arrived
//   busy                an instruction is in flight or commands are queued
// ---------------------------------------------------------------------------
module vec_issue_unit
    import vec_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [XLEN-1:0] cmd_inst,
    input  logic [XLEN-1:0] cmd_rs1,
    input  logic [XLEN-1:0] cmd_rs2,

    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,

    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            inst_valid,
    output logic            scalar_pro_ready,
    input  logic            vec_pro_ready,
    input  logic            vec_pro_ack,
    input  logic            is_vec,
    input  logic [XLEN-1:0] csr_out,

    output logic            illegal_inst,
    output logic            timeout_err,
    output logic            busy
);

    localparam int               CNT_W      = timeout_cnt_width(TIMEOUT);
    localparam int               FIFO_CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    issue_state_e          state;
    issue_state_e          next_state;

    issue_cmd_t            cmd_in;
    issue_cmd_t            fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [FIFO_CNT_W-1:0] fifo_count;

    logic [CNT_W-1:0]      wait_cnt;
    logic                  wait_last;
    logic                  reject;
    logic                  complete;
    logic                  expire;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    assign cmd_in = '{inst: cmd_inst, rs1: cmd_rs1, rs2: cmd_rs2};

    vec_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign wait_last = (wait_cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                // A rejected instruction gets no ack, so it goes straight back.
                if (vec_pro_ready) begin
                    next_state = is_vec ? WAIT_ACK : IDLE;
                end
            end
            WAIT_ACK: begin
                // Completion wins over expiry when both land on the last cycle.
                if ((vec_pro_ack && !res_valid) || wait_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / event decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        fifo_pop         = 1'b0;
        inst_valid       = 1'b0;
        scalar_pro_ready = 1'b0;
        reject           = 1'b0;
        complete         = 1'b0;
        expire           = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
            end
            ISSUE: begin
                inst_valid = 1'b1;
                reject     = vec_pro_ready && !is_vec;
            end
            WAIT_ACK: begin
                // A held result blocks completion, which is what makes
                // consume and capture in the same cycle impossible.
                scalar_pro_ready = !res_valid;
                complete         = vec_pro_ack && !res_valid;
                expire           = !complete && wait_last;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand registers, wait counter, result register and error pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction  <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            wait_cnt     <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            illegal_inst <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            illegal_inst <= reject;
            timeout_err  <= expire;

            // Operands only change on a pop, so they stay stable through
            // ISSUE and WAIT_ACK.
            if (fifo_pop) begin
                instruction <= fifo_head.inst;
                rs1_data    <= fifo_head.rs1;
                rs2_data    <= fifo_head.rs2;
            end

            // Keeps counting while back-pressured by a held result.
            if ((state == WAIT_ACK) && !complete && !expire) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (complete) begin
                res_valid <= 1'b1;
                res_data  <= csr_out;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_issue_unit
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference (a queue of pending commands plus the single in-flight command)
// predicts every output each cycle; a compare process checks the DUT against
// it on every falling edge. Directed scenarios add hand-computed literal
// expectations.
// ---------------------------------------------------------------------------
module tb_vec_issue_unit;
    import vec_issue_pkg::*;

    localparam int              DEPTH   = 4;
    localparam int              TIMEOUT = 16;
    localparam logic [XLEN-1:0] ECHO_KEY = 32'h5A5A_0F0F;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [XLEN-1:0] cmd_inst = '0;
    logic [XLEN-1:0] cmd_rs1 = '0;
    logic [XLEN-1:0] cmd_rs2 = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [XLEN-1:0] res_data;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            inst_valid;
    logic            scalar_pro_ready;
    logic            vec_pro_ready = 1'b0;
    logic            vec_pro_ack = 1'b0;
    logic            is_vec = 1'b0;
    logic [XLEN-1:0] csr_out;
    logic [XLEN-1:0] csr_drv = '0;
    logic            echo_mode = 1'b0;
    logic            illegal_inst;
    logic            timeout_err;
    logic            busy;

    // In echo mode the vector side answers with a value derived from the
    // instruction it was given, so results can be matched to commands.
    assign csr_out = echo_mode ? (instruction ^ ECHO_KEY) : csr_drv;

    vec_issue_unit #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_inst         (cmd_inst),
        .cmd_rs1          (cmd_rs1),
        .cmd_rs2          (cmd_rs2),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .instruction      (instruction),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .inst_valid       (inst_valid),
        .scalar_pro_ready (scalar_pro_ready),
        .vec_pro_ready    (vec_pro_ready),
        .vec_pro_ack      (vec_pro_ack),
        .is_vec           (is_vec),
        .csr_out          (csr_out),
        .illegal_inst     (illegal_inst),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    initial forever #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Check bookkeeping
    // -----------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // -----------------------------------------------------------------------
    // Reference model: pending queue + at most one in-flight command.
    // m_offered : in-flight command is being offered to the vector side
    // m_waited  : cycles spent waiting for completion so far
    // -----------------------------------------------------------------------
    issue_cmd_t      m_q[$];
    bit              m_inflight = 0;
    bit              m_offered  = 0;
    int              m_waited   = 0;
    issue_cmd_t      m_out      = '0;
    bit              m_res_valid = 0;
    logic [XLEN-1:0] m_res_data = '0;
    bit              m_illegal = 0;
    bit              m_timeout = 0;

    task automatic model_step();
        bit         held_result;
        int         pending;
        issue_cmd_t c;
        if (!reset) begin
            m_q.delete();
            m_inflight  = 0;
            m_offered   = 0;
            m_waited    = 0;
            m_out       = '0;
            m_res_valid = 0;
            m_res_data  = '0;
            m_illegal   = 0;
            m_timeout   = 0;
            return;
        end
        held_result = m_res_valid;
        pending     = m_q.size();
        m_illegal   = 0;
        m_timeout   = 0;
        if (held_result && res_ready) m_res_valid = 0;
        if (!m_inflight) begin
            if (pending > 0) begin
                m_out      = m_q.pop_front();
                m_inflight = 1;
                m_offered  = 1;
            end
        end else if (m_offered) begin
            if (vec_pro_ready) begin
                m_offered = 0;
                m_waited  = 0;
                if (!is_vec) begin
                    m_illegal  = 1;
                    m_inflight = 0;
                end
            end
        end else begin
            if (vec_pro_ack && !held_result) begin
                m_res_valid = 1;
                m_res_data  = csr_out;
                m_inflight  = 0;
            end else if (m_waited + 1 >= TIMEOUT) begin
                m_timeout  = 1;
                m_inflight = 0;
            end else begin
                m_waited++;
            end
        end
        if (cmd_valid && pending < DEPTH) begin
            c.inst = cmd_inst;
            c.rs1  = cmd_rs1;
            c.rs2  = cmd_rs2;
            m_q.push_back(c);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("cmd_ready", cmd_ready, m_q.size() < DEPTH);
            check("busy", busy, m_inflight || m_q.size() > 0);
            check("inst_valid", inst_valid, m_inflight && m_offered);
            check("scalar_pro_ready", scalar_pro_ready, m_inflight && !m_offered && !m_res_valid);
            check("instruction", instruction, m_out.inst);
            check("rs1_data", rs1_data, m_out.rs1);
            check("rs2_data", rs2_data, m_out.rs2);
            check("res_valid", res_valid, m_res_valid);
            check("res_data", res_data, m_res_data);
            check("illegal_inst", illegal_inst, m_illegal);
            check("timeout_err", timeout_err, m_timeout);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [XLEN-1:0] i, input logic [XLEN-1:0] r1,
                            input logic [XLEN-1:0] r2);
        cmd_valid = 1'b1;
        cmd_inst  = i;
        cmd_rs1   = r1;
        cmd_rs2   = r2;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] got_q[$];

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst inst_valid", inst_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst res_valid", res_valid, 1'b0);
        check("rst instruction", instruction, '0);
        check("rst scalar_pro_ready", scalar_pro_ready, 1'b0);
        #2 reset = 1'b1;
        #1 check("cmd_ready after reset", cmd_ready, 1'b1);
        tick();

        // ---------------- 1: vsetvli, ack 3 cycles after transfer ----------------
        vec_pro_ready = 1'b1;
        is_vec        = 1'b1;
        push_cmd(32'h0C05_72D7, 32'd8, 32'd0);
        check("t1 inst_valid at N+1", inst_valid, 1'b0);
        tick();
        check("t1 inst_valid at N+2", inst_valid, 1'b1);
        check("t1 instruction", instruction, 32'h0C05_72D7);
        check("t1 rs1_data", rs1_data, 32'd8);
        tick();
        check("t1 inst_valid one cycle", inst_valid, 1'b0);
        check("t1 scalar_pro_ready", scalar_pro_ready, 1'b1);
        tick();
        tick();
        vec_pro_ack = 1'b1;
        csr_drv     = 32'd8;
        tick();
        vec_pro_ack = 1'b0;
        check("t1 res_valid", res_valid, 1'b1);
        check("t1 res_data", res_data, 32'd8);
        check("t1 model res_data", m_res_data, 32'd8);
        check("t1 busy", busy, 1'b0);
        consume_result();
        check("t1 res_valid cleared", res_valid, 1'b0);

        // ---------------- 2: stall in ISSUE for 5 cycles ----------------
        vec_pro_ready = 1'b0;
        push_cmd(32'h0205_7057, 32'h11, 32'h22);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2 inst_valid held", inst_valid, 1'b1);
            check("t2 instruction held", instruction, 32'h0205_7057);
            check("t2 rs1 held", rs1_data, 32'h11);
            check("t2 rs2 held", rs2_data, 32'h22);
            tick();
        end
        vec_pro_ready = 1'b1;
        check("t2 inst_valid cycle 6", inst_valid, 1'b1);
        tick();
        check("t2 transferred", inst_valid, 1'b0);
        check("t2 no illegal", illegal_inst, 1'b0);
        vec_pro_ack = 1'b1;
        csr_drv     = 32'h77;
        tick();
        vec_pro_ack = 1'b0;
        check("t2 res_data", res_data, 32'h77);
        consume_result();

        // ---------------- 3: illegal instruction then a legal one ----------------
        vec_pro_ready = 1'b0;
        push_cmd(32'h0000_0013, 32'h1, 32'h2);
        push_cmd(32'h02A5_8057, 32'h3, 32'h4);
        check("t3 first presented", instruction, 32'h0000_0013);
        vec_pro_ready = 1'b1;
        is_vec        = 1'b0;
        tick();
        is_vec = 1'b1;
        check("t3 illegal pulse", illegal_inst, 1'b1);
        check("t3 no wait", scalar_pro_ready, 1'b0);
        tick();
        check("t3 illegal once", illegal_inst, 1'b0);
        check("t3 next issued", instruction, 32'h02A5_8057);
        check("t3 next inst_valid", inst_valid, 1'b1);
        tick();
        check("t3 no result", res_valid, 1'b0);
        vec_pro_ack = 1'b1;
        csr_drv     = 32'h33;
        tick();
        vec_pro_ack = 1'b0;
        check("t3 res_data", res_data, 32'h33);
        consume_result();

        // ---------------- 4: ack timeout ----------------
        push_cmd(32'h5E00_30D7, 32'h5, 32'h6);
        tick();
        tick();
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check("t4 no early timeout", timeout_err, 1'b0);
        end
        tick();
        check("t4 timeout pulse", timeout_err, 1'b1);
        check("t4 model timeout", m_timeout, 1'b1);
        check("t4 busy", busy, 1'b0);
        tick();
        check("t4 timeout once", timeout_err, 1'b0);

        // ---------------- 5: fill FIFO, drain in order ----------------
        vec_pro_ready = 1'b0;
        res_ready     = 1'b1;
        echo_mode     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [XLEN-1:0] inst_i;
            inst_i = 32'h1000_0057 + (i << 12);
            exp_q.push_back(inst_i ^ ECHO_KEY);
            check("t5 ready before push", cmd_ready, 1'b1);
            push_cmd(inst_i, i, ~i);
        end
        check("t5 full", cmd_ready, 1'b0);
        vec_pro_ready = 1'b1;
        vec_pro_ack   = 1'b1;
        for (int c = 0; c < 80 && got_q.size() < 5; c++) begin
            if (res_valid && res_ready) got_q.push_back(res_data);
            tick();
        end
        check("t5 result count", got_q.size(), 5);
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            check("t5 result order", got_q[i], exp_q[i]);
        end
        vec_pro_ack = 1'b0;
        res_ready   = 1'b0;
        echo_mode   = 1'b0;
        tick();

        // ---------------- 6: result back-pressure ----------------
        push_cmd(32'h00A5_7057, 32'hA1, 32'hA2);
        tick();
        tick();
        vec_pro_ack = 1'b1;
        csr_drv     = 32'hAAAA;
        tick();
        vec_pro_ack = 1'b0;
        push_cmd(32'h00B5_7057, 32'hB1, 32'hB2);
        tick();
        tick();
        check("t6 blocked scalar_pro_ready", scalar_pro_ready, 1'b0);
        vec_pro_ack = 1'b1;
        csr_drv     = 32'hBBBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6 old result held", res_data, 32'hAAAA);
            check("t6 still busy", busy, 1'b1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t6 consumed", res_valid, 1'b0);
        check("t6 ready again", scalar_pro_ready, 1'b1);
        tick();
        vec_pro_ack = 1'b0;
        check("t6 completion", res_valid, 1'b1);
        check("t6 res_data", res_data, 32'hBBBB);
        consume_result();

        // ---------------- 6b: reset mid-WAIT_ACK ----------------
        push_cmd(32'h00C5_7057, 32'hC1, 32'hC2);
        tick();
        tick();
        push_cmd(32'h00D5_7057, 32'hD1, 32'hD2);
        push_cmd(32'h00E5_7057, 32'hE1, 32'hE2);
        check("t6b waiting", scalar_pro_ready, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t6b rst inst_valid", inst_valid, 1'b0);
        check("t6b rst scalar_pro_ready", scalar_pro_ready, 1'b0);
        check("t6b rst instruction", instruction, '0);
        check("t6b rst rs1_data", rs1_data, '0);
        check("t6b rst rs2_data", rs2_data, '0);
        check("t6b rst res_valid", res_valid, 1'b0);
        check("t6b rst res_data", res_data, '0);
        check("t6b rst illegal", illegal_inst, 1'b0);
        check("t6b rst timeout", timeout_err, 1'b0);
        check("t6b rst busy", busy, 1'b0);
        tick();
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        check("t6b fifo empty", busy, 1'b0);
        check("t6b cmd_ready", cmd_ready, 1'b1);
        tick();
        check("t6b nothing issued", inst_valid, 1'b0);

        // ---------------- random traffic ----------------
        for (int seg = 0; seg < 6; seg++) begin
            int ack_pct;
            int rdy_pct;
            ack_pct = (seg % 3 == 2) ? 3 : 35;
            rdy_pct = (seg % 2 == 0) ? 70 : 20;
            for (int n = 0; n < 500; n++) begin
                cmd_valid     = ($urandom_range(0, 99) < 40);
                cmd_inst      = $urandom;
                cmd_rs1       = $urandom;
                cmd_rs2       = $urandom;
                vec_pro_ready = ($urandom_range(0, 99) < 60);
                is_vec        = ($urandom_range(0, 99) < 85);
                vec_pro_ack   = ($urandom_range(0, 99) < ack_pct);
                res_ready     = ($urandom_range(0, 99) < rdy_pct);
                csr_drv       = $urandom;
                tick();
            end
        end
        cmd_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_issue_unit.md
Name: vec_issue_unit

Overview:
- Scalar-side issuer that drives the vector processor's instruction val/ready interface: `instruction`, `rs1_data`, `rs2_data`, `inst_valid` and `scalar_pro_ready`.
- It consumes `vec_pro_ready`, `vec_pro_ack`, `is_vec` and `csr_out`.
- It buffers scalar-core vector commands in a small FIFO and issues them one at a time, holding operands stable until completion.
- It returns `csr_out` to the core through a result register, and reports illegal instructions and ack timeouts.

Parameters:
- XLEN, `XLEN (32), data/instruction width, taken from vector_processor_defs.svh
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 1024, maximum WAIT_ACK cycles before abort (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  core offers a command
- cmd_ready  out  1  FIFO not full
- cmd_inst  in  XLEN  vector instruction
- cmd_rs1  in  XLEN  scalar rs1 operand
- cmd_rs2  in  XLEN  scalar rs2 operand
- res_valid  out  1  result held for the core
- res_ready  in  1  core accepts the result
- res_data  out  XLEN  captured csr_out
- instruction  out  XLEN  to the vector processor
- rs1_data  out  XLEN  to the vector processor
- rs2_data  out  XLEN  to the vector processor
- inst_valid  out  1  instruction offered
- scalar_pro_ready  out  1  issuer can take completion
- vec_pro_ready  in  1  vector processor accepts the instruction
- vec_pro_ack  in  1  vector processor completed the instruction
- is_vec  in  1  presented instruction is a legal vector instruction
- csr_out  in  XLEN  vector CSR read data
- illegal_inst  out  1  one-cycle pulse, instruction rejected
- timeout_err  out  1  one-cycle pulse, ack timeout
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, asynchronous): the following are all 0:
  - FIFO empty, state IDLE, timeout counter 0
  - `inst_valid`, `scalar_pro_ready`, `instruction`, `rs1_data`, `rs2_data`
  - `res_valid`, `res_data`, `illegal_inst`, `timeout_err`, `busy`
  - `cmd_ready`=1 once reset deasserts.
  - Reset in any state discards the in-flight instruction and all FIFO contents.
- FIFO:
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`; no same-cycle bypass when full.
  - Pointers wrap modulo DEPTH; count is tracked with a DEPTH+1-range counter.
- IDLE:
  - If the FIFO is non-empty: pop the head, register `{instruction, rs1_data, rs2_data}` and go to ISSUE.
  - Latency: a command pushed at edge N is presented with `inst_valid`=1 in cycle N+2.
- ISSUE:
  - `inst_valid`=1; outputs are held stable.
  - On `vec_pro_ready`=1 with `is_vec`=1 → go to WAIT_ACK, and `inst_valid` drops the next cycle.
  - On `vec_pro_ready`=1 with `is_vec`=0 → pulse `illegal_inst` the next cycle, go to IDLE, drop the instruction. No ack is expected for it.
  - `vec_pro_ready`=0 → stay in ISSUE indefinitely (no timeout here).
- WAIT_ACK:
  - `instruction`/`rs1_data`/`rs2_data` stay stable, because the vector datapath decodes them combinationally.
  - `scalar_pro_ready = !res_valid` (combinational).
  - On `vec_pro_ack && scalar_pro_ready`: `res_data` ← `csr_out`, `res_valid` ← 1, timeout counter clears, go to IDLE.
  - Otherwise the counter increments each cycle. On reaching TIMEOUT-1 without completion: pulse `timeout_err` the next cycle, go to IDLE, drop the instruction.
  - The counter also runs while back-pressured by `res_valid`.
- Result register:
  - `res_valid` clears on `res_valid && res_ready`.
  - Consuming the result and capturing a new one in the same cycle is impossible by construction, since `scalar_pro_ready` depends on `res_valid`.
- `vec_pro_ack` outside WAIT_ACK is ignored.
- An `is_vec` value outside ISSUE is ignored.
- Only one instruction is ever outstanding.

Decomposition:
- Package vec_issue_pkg:
  - state enum `issue_state_e` {IDLE, ISSUE, WAIT_ACK}
  - packed struct `issue_cmd_t` {inst, rs1, rs2}
  - localparam for the timeout counter width
- Sub-module vec_issue_fifo:
  - parameterised DEPTH, stores `issue_cmd_t`
  - push/pop/full/empty/count
- The top level holds the FSM, output registers, timeout counter and result register.

Test Plan:
1. Push vsetvli 0x0C0572D7 with rs1=8 while the vector side keeps `vec_pro_ready`=1 and `is_vec`=1, then acks 3 cycles later with `csr_out`=8. Required: `inst_valid` high for exactly one cycle at N+2, `scalar_pro_ready`=1 in WAIT_ACK, then `res_valid`=1 with `res_data`=8.
2. Hold `vec_pro_ready`=0 for 5 cycles during ISSUE. Required: `inst_valid` and all operands stable for 6 cycles; transfer happens on the 6th cycle; no `illegal_inst` or `timeout_err`.
3. Push 0x00000013 with `is_vec`=0. Required: `illegal_inst` pulses exactly once, no WAIT_ACK, `res_valid` stays 0, and the next queued command issues normally.
4. With TIMEOUT=16, enter WAIT_ACK and never ack. Required: `timeout_err` pulses 16 cycles after entry, state returns to IDLE, `busy`=0 if the FIFO is empty.
5. With DEPTH=4, push 5 back-to-back commands while `vec_pro_ready`=0. Required: `cmd_ready`=0 after the 4th push plus the one popped to ISSUE; no data loss; all commands issue in order and results return in order with `res_ready`=1.
6. Hold `res_ready`=0 with `res_valid`=1 and a second instruction in WAIT_ACK. Required: `scalar_pro_ready`=0, the ack is not consumed, and completion follows the cycle after `res_ready` rises. Separately, assert reset mid-WAIT_ACK: all outputs go to 0 immediately and the FIFO is empty after release.
